// File: rtl/load_hash.sv
// load_hash
//   Reads HASH_LENGTH consecutive words from the hash memory, starting at a
//   captured base address, and assembles them into one hash vector. Memory
//   word i lands in hash_vector[i*WORD_WIDTH +: WORD_WIDTH]. It is used to
//   reload an intermediate hash state before a compression round.
//
// Ports
//   clock          in   system clock, rising edge
//   reset          in   synchronous, active-high
//   start          in   load request, sampled only while idle
//   base_address   in   address of word 0, captured together with start
//   mem_read_en    out  memory read strobe (registered)
//   mem_address    out  memory read address (registered)
//   mem_read_data  in   read data, valid READ_LATENCY cycles after the strobe
//   hash_vector    out  assembled vector, held until overwritten
//   hash_valid     out  one-cycle pulse, hash_vector complete
//   busy           out  high while a load is in progress (through the DONE cycle)
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// ISSUE | one read strobe per cycle, HASH_LENGTH strobes in total
// DRAIN | strobes finished, collecting the words still in flight
// DONE  | hash_valid high for this single cycle

module load_hash #(
    parameter int HASH_LENGTH  = 8,
    parameter int WORD_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic [ADDR_WIDTH-1:0]             base_address,
    output logic                              mem_read_en,
    output logic [ADDR_WIDTH-1:0]             mem_address,
    input  logic [WORD_WIDTH-1:0]             mem_read_data,
    output logic [HASH_LENGTH*WORD_WIDTH-1:0] hash_vector,
    output logic                              hash_valid,
    output logic                              busy
);

    localparam int CNT_W = $clog2(HASH_LENGTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   base_q, base_nxt;
    logic [CNT_W-1:0]        issue_cnt, issue_cnt_nxt;
    logic [CNT_W-1:0]        capt_cnt, capt_cnt_nxt;
    logic [READ_LATENCY-1:0] vld_pipe;
    logic                    capt_fire;
    logic                    rd_en_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic                    valid_nxt;
    logic                    busy_nxt;

    // The valid pipeline tracks the registered strobe, so its last stage lines
    // up with the cycle in which the memory presents the matching word.
    assign capt_fire = vld_pipe[READ_LATENCY-1] && ((state == ISSUE) || (state == DRAIN));

    always_comb begin
        state_nxt     = state;
        base_nxt      = base_q;
        issue_cnt_nxt = issue_cnt;
        capt_cnt_nxt  = capt_cnt;
        rd_en_nxt     = 1'b0;
        addr_nxt      = mem_address;
        valid_nxt     = 1'b0;

        if (capt_fire) begin
            capt_cnt_nxt = capt_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (start) begin
                    base_nxt      = base_address;
                    issue_cnt_nxt = CNT_W'(1);
                    capt_cnt_nxt  = '0;
                    rd_en_nxt     = 1'b1;
                    addr_nxt      = base_address;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                // issue_cnt counts strobes already launched; the first one
                // leaves together with the IDLE->ISSUE transition.
                if (issue_cnt == CNT_W'(HASH_LENGTH)) begin
                    state_nxt = DRAIN;
                end else begin
                    rd_en_nxt     = 1'b1;
                    addr_nxt      = base_q + ADDR_WIDTH'(issue_cnt);
                    issue_cnt_nxt = issue_cnt + 1'b1;
                end
            end
            DRAIN: begin
                // Raising hash_valid together with the last capture keeps the
                // pulse in the cycle right after the final word is stored.
                if (capt_fire && (capt_cnt == CNT_W'(HASH_LENGTH - 1))) begin
                    valid_nxt = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            base_q      <= '0;
            issue_cnt   <= '0;
            capt_cnt    <= '0;
            vld_pipe    <= '0;
            mem_read_en <= 1'b0;
            mem_address <= '0;
            hash_vector <= '0;
            hash_valid  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            base_q      <= base_nxt;
            issue_cnt   <= issue_cnt_nxt;
            capt_cnt    <= capt_cnt_nxt;
            mem_read_en <= rd_en_nxt;
            mem_address <= addr_nxt;
            hash_valid  <= valid_nxt;
            busy        <= busy_nxt;

            vld_pipe[0] <= mem_read_en;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end

            if (capt_fire) begin
                hash_vector[capt_cnt*WORD_WIDTH +: WORD_WIDTH] <= mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_load_hash.sv
module tb_load_hash;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset;
    logic         a_start, b_start;
    logic [7:0]   a_base, b_base;
    logic         a_en, b_en;
    logic [7:0]   a_addr, b_addr;
    logic [31:0]  a_rdata, b_rdata;
    logic [255:0] a_vec, b_vec;
    logic         a_valid, b_valid;
    logic         a_busy, b_busy;

    load_hash dut_a (
        .clock(clock), .reset(reset), .start(a_start), .base_address(a_base),
        .mem_read_en(a_en), .mem_address(a_addr), .mem_read_data(a_rdata),
        .hash_vector(a_vec), .hash_valid(a_valid), .busy(a_busy)
    );

    load_hash #(.READ_LATENCY(3)) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .base_address(b_base),
        .mem_read_en(b_en), .mem_address(b_addr), .mem_read_data(b_rdata),
        .hash_vector(b_vec), .hash_valid(b_valid), .busy(b_busy)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // memory model: latency 1 for dut_a, latency 3 for dut_b
    logic [31:0] mem [256];
    logic [31:0] b_p0, b_p1;
    always @(posedge clock) begin
        a_rdata <= a_en ? mem[a_addr] : 32'hDEADBEEF;
        b_p0    <= b_en ? mem[b_addr] : 32'hDEADBEEF;
        b_p1    <= b_p0;
        b_rdata <= b_p1;
    end

    int          a_strobe_cyc[$], b_strobe_cyc[$];
    logic [7:0]  a_strobe_addr[$], b_strobe_addr[$];
    int          a_valid_cyc[$], b_valid_cyc[$];
    logic [255:0] a_valid_vec[$], b_valid_vec[$];
    int          a_busy_cyc[$], b_busy_cyc[$];

    always @(negedge clock) begin
        if (a_en === 1'b1) begin a_strobe_cyc.push_back(cyc); a_strobe_addr.push_back(a_addr); end
        if (b_en === 1'b1) begin b_strobe_cyc.push_back(cyc); b_strobe_addr.push_back(b_addr); end
        if (a_valid === 1'b1) begin a_valid_cyc.push_back(cyc); a_valid_vec.push_back(a_vec); end
        if (b_valid === 1'b1) begin b_valid_cyc.push_back(cyc); b_valid_vec.push_back(b_vec); end
        if (a_busy === 1'b1) a_busy_cyc.push_back(cyc);
        if (b_busy === 1'b1) b_busy_cyc.push_back(cyc);
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic clear_logs();
        a_strobe_cyc.delete(); a_strobe_addr.delete(); a_valid_cyc.delete();
        a_valid_vec.delete(); a_busy_cyc.delete();
        b_strobe_cyc.delete(); b_strobe_addr.delete(); b_valid_cyc.delete();
        b_valid_vec.delete(); b_busy_cyc.delete();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    task automatic pulse_a(input logic [7:0] base, output int s);
        @(negedge clock);
        a_start = 1'b1; a_base = base; s = cyc;
        @(negedge clock);
        a_start = 1'b0;
    endtask

    task automatic pulse_b(input logic [7:0] base, output int s);
        @(negedge clock);
        b_start = 1'b1; b_base = base; s = cyc;
        @(negedge clock);
        b_start = 1'b0;
    endtask

    function automatic logic [255:0] basic_vec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = 32'h11111111 * 32'(i + 1);
        return v;
    endfunction

    function automatic logic [255:0] pattern_vec(input logic [7:0] base);
        logic [255:0] v;
        logic [7:0] ad;
        for (int i = 0; i < 8; i++) begin
            ad = base + 8'(i);
            v[i*32 +: 32] = 32'hC0DE0000 | {24'h0, ad};
        end
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1; a_start = 1'b0; b_start = 1'b0; a_base = 8'h00; b_base = 8'h00;
        repeat (3) @(negedge clock);
        n_total++; if (a_en !== 1'b0) $display("FAIL reset_en got %b want 0", a_en); else n_pass++;
        n_total++; if (a_addr !== 8'h00) $display("FAIL reset_addr got %h want 00", a_addr); else n_pass++;
        n_total++; if (a_vec !== 256'h0) $display("FAIL reset_vec got %h want 0", a_vec); else n_pass++;
        n_total++; if (a_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", a_valid); else n_pass++;
        n_total++; if (a_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", a_busy); else n_pass++;
        // reset and start together: reset wins
        a_start = 1'b1; a_base = 8'h10;
        @(negedge clock);
        n_total++; if (a_busy !== 1'b0 || a_en !== 1'b0)
            $display("FAIL reset_with_start busy=%b en=%b want 0 0", a_busy, a_en); else n_pass++;
        a_start = 1'b0; reset = 1'b0;
        @(negedge clock);
        n_total++; if (a_busy !== 1'b0 || a_en !== 1'b0)
            $display("FAIL reset_with_start_after busy=%b en=%b want 0 0", a_busy, a_en); else n_pass++;
    endtask

    task automatic test_basic();
        int s;
        clear_logs();
        pulse_a(8'h10, s);
        wait_until(s + 14);
        n_total++; if (a_strobe_cyc.size() != 8) $display("FAIL basic_strobe_count got %0d want 8", a_strobe_cyc.size()); else n_pass++;
        for (int i = 0; i < 8 && i < a_strobe_cyc.size(); i++) begin
            n_total++;
            if (a_strobe_cyc[i] != s + 1 + i || a_strobe_addr[i] !== 8'h10 + 8'(i))
                $display("FAIL basic_strobe%0d got cyc %0d addr %h want cyc %0d addr %h",
                         i, a_strobe_cyc[i] - s, a_strobe_addr[i], 1 + i, 8'h10 + 8'(i));
            else n_pass++;
        end
        n_total++; if (a_valid_cyc.size() != 1) $display("FAIL basic_valid_count got %0d want 1", a_valid_cyc.size()); else n_pass++;
        if (a_valid_cyc.size() > 0) begin
            n_total++; if (a_valid_cyc[0] != s + 10) $display("FAIL basic_valid_cycle got S+%0d want S+10", a_valid_cyc[0] - s); else n_pass++;
            n_total++; if (a_valid_vec[0] !== basic_vec()) $display("FAIL basic_vec got %h want %h", a_valid_vec[0], basic_vec()); else n_pass++;
        end
        n_total++; if (a_busy_cyc.size() != 10 || a_busy_cyc[0] != s + 1)
            $display("FAIL basic_busy got %0d cycles want 10 from S+1", a_busy_cyc.size()); else n_pass++;
        n_total++; if (a_vec !== basic_vec()) $display("FAIL basic_vec_held got %h want %h", a_vec, basic_vec()); else n_pass++;
    endtask

    task automatic test_wrap();
        int s;
        logic [7:0] ea;
        clear_logs();
        pulse_a(8'hFE, s);
        wait_until(s + 14);
        n_total++; if (a_strobe_addr.size() != 8) $display("FAIL wrap_strobe_count got %0d want 8", a_strobe_addr.size()); else n_pass++;
        for (int i = 0; i < 8 && i < a_strobe_addr.size(); i++) begin
            ea = 8'hFE + 8'(i);
            n_total++;
            if (a_strobe_addr[i] !== ea) $display("FAIL wrap_addr%0d got %h want %h", i, a_strobe_addr[i], ea);
            else n_pass++;
        end
        n_total++; if (a_vec[31:0] !== 32'hC0DE00FE) $display("FAIL wrap_word0 got %h want c0de00fe", a_vec[31:0]); else n_pass++;
        n_total++; if (a_vec[255:224] !== 32'hC0DE0005) $display("FAIL wrap_word7 got %h want c0de0005", a_vec[255:224]); else n_pass++;
        n_total++; if (a_vec !== pattern_vec(8'hFE)) $display("FAIL wrap_vec got %h want %h", a_vec, pattern_vec(8'hFE)); else n_pass++;
    endtask

    task automatic test_start_busy();
        int s;
        int found;
        clear_logs();
        pulse_a(8'h10, s);
        wait_until(s + 3);
        a_start = 1'b1; a_base = 8'h40;
        @(negedge clock);
        a_start = 1'b0;
        wait_until(s + 10);
        a_start = 1'b1; a_base = 8'h60;
        @(negedge clock);
        a_start = 1'b0;
        wait_until(s + 22);
        found = 0;
        foreach (a_strobe_addr[i]) if (a_strobe_addr[i] == 8'h40 || a_strobe_addr[i] == 8'h60) found++;
        n_total++; if (found != 0) $display("FAIL busy_ignored_addr got %0d ignored-base strobes want 0", found); else n_pass++;
        n_total++; if (a_strobe_cyc.size() != 8) $display("FAIL busy_strobe_count got %0d want 8", a_strobe_cyc.size()); else n_pass++;
        n_total++; if (a_valid_cyc.size() != 1) $display("FAIL busy_valid_count got %0d want 1", a_valid_cyc.size()); else n_pass++;
        if (a_valid_cyc.size() > 0) begin
            n_total++; if (a_valid_cyc[0] != s + 10) $display("FAIL busy_valid_cycle got S+%0d want S+10", a_valid_cyc[0] - s); else n_pass++;
        end
        n_total++; if (a_busy_cyc.size() != 10) $display("FAIL busy_cycles got %0d want 10", a_busy_cyc.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int s;
        clear_logs();
        pulse_a(8'h30, s);
        wait_until(s + 4);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_total++; if (a_en !== 1'b0) $display("FAIL mid_reset_en got %b want 0", a_en); else n_pass++;
        n_total++; if (a_busy !== 1'b0) $display("FAIL mid_reset_busy got %b want 0", a_busy); else n_pass++;
        n_total++; if (a_vec !== 256'h0) $display("FAIL mid_reset_vec got %h want 0", a_vec); else n_pass++;
        wait_until(s + 16);
        n_total++; if (a_strobe_cyc.size() != 4) $display("FAIL mid_reset_strobes got %0d want 4", a_strobe_cyc.size()); else n_pass++;
        n_total++; if (a_valid_cyc.size() != 0) $display("FAIL mid_reset_valid got %0d pulses want 0", a_valid_cyc.size()); else n_pass++;
        clear_logs();
        pulse_a(8'h10, s);
        wait_until(s + 14);
        n_total++; if (a_valid_cyc.size() != 1 || a_valid_cyc[0] != s + 10)
            $display("FAIL mid_reset_reload_valid got %0d pulses want 1 at S+10", a_valid_cyc.size()); else n_pass++;
        n_total++; if (a_vec !== basic_vec()) $display("FAIL mid_reset_reload_vec got %h want %h", a_vec, basic_vec()); else n_pass++;
    endtask

    task automatic test_latency3();
        int s;
        clear_logs();
        pulse_b(8'h10, s);
        wait_until(s + 16);
        n_total++; if (b_strobe_cyc.size() != 8) $display("FAIL lat3_strobe_count got %0d want 8", b_strobe_cyc.size()); else n_pass++;
        if (b_strobe_cyc.size() == 8) begin
            n_total++; if (b_strobe_cyc[0] != s + 1 || b_strobe_cyc[7] != s + 8)
                $display("FAIL lat3_strobe_window got S+%0d..S+%0d want S+1..S+8", b_strobe_cyc[0] - s, b_strobe_cyc[7] - s); else n_pass++;
        end
        n_total++; if (b_valid_cyc.size() != 1) $display("FAIL lat3_valid_count got %0d want 1", b_valid_cyc.size()); else n_pass++;
        if (b_valid_cyc.size() > 0) begin
            n_total++; if (b_valid_cyc[0] != s + 12) $display("FAIL lat3_valid_cycle got S+%0d want S+12", b_valid_cyc[0] - s); else n_pass++;
            n_total++; if (b_valid_vec[0] !== basic_vec()) $display("FAIL lat3_vec got %h want %h", b_valid_vec[0], basic_vec()); else n_pass++;
        end
        n_total++; if (b_busy_cyc.size() != 12) $display("FAIL lat3_busy got %0d cycles want 12", b_busy_cyc.size()); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int s;
        clear_logs();
        pulse_a(8'h30, s);
        wait_until(s + 11);
        a_start = 1'b1; a_base = 8'h20;
        @(negedge clock);
        a_start = 1'b0;
        wait_until(s + 25);
        n_total++; if (a_valid_cyc.size() != 2) $display("FAIL b2b_valid_count got %0d want 2", a_valid_cyc.size()); else n_pass++;
        if (a_valid_cyc.size() == 2) begin
            n_total++; if (a_valid_cyc[0] != s + 10 || a_valid_cyc[1] != s + 21)
                $display("FAIL b2b_valid_cycles got S+%0d,S+%0d want S+10,S+21", a_valid_cyc[0] - s, a_valid_cyc[1] - s); else n_pass++;
            n_total++; if (a_valid_vec[0] !== pattern_vec(8'h30)) $display("FAIL b2b_vec0 got %h want %h", a_valid_vec[0], pattern_vec(8'h30)); else n_pass++;
            n_total++; if (a_valid_vec[1] !== pattern_vec(8'h20)) $display("FAIL b2b_vec1 got %h want %h", a_valid_vec[1], pattern_vec(8'h20)); else n_pass++;
        end
        n_total++; if (a_strobe_cyc.size() != 16) $display("FAIL b2b_strobe_count got %0d want 16", a_strobe_cyc.size()); else n_pass++;
        if (a_strobe_cyc.size() == 16) begin
            n_total++; if (a_strobe_cyc[8] != s + 12 || a_strobe_addr[8] !== 8'h20)
                $display("FAIL b2b_second_first_strobe got S+%0d addr %h want S+12 addr 20", a_strobe_cyc[8] - s, a_strobe_addr[8]); else n_pass++;
        end
        n_total++; if (a_busy_cyc.size() != 20) $display("FAIL b2b_busy got %0d cycles want 20", a_busy_cyc.size()); else n_pass++;
    endtask

    initial begin
        logic [7:0] ad;
        for (int i = 0; i < 256; i++) begin
            ad = 8'(i);
            mem[i] = 32'hC0DE0000 | {24'h0, ad};
        end
        for (int i = 0; i < 8; i++) mem[16 + i] = 32'h11111111 * 32'(i + 1);

        test_reset();
        test_basic();
        test_wrap();
        test_start_busy();
        test_reset_mid();
        test_latency3();
        test_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
